fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 10'd0: instruction index fetched first after reset.
REQ-002 Parameter DEPTH, default 2: fetch buffer entries, legal range 2..8.
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc_out  output  10  instruction index driven to instruction memory.
REQ-006 insn_out  input  32  instruction memory read data, combinational from pc_out, same cycle.
REQ-007 if_valid  output  1  buffer head holds a valid instruction.
REQ-008 if_ready  input  1  decode accepts the head entry this cycle.
REQ-009 if_insn  output  32  instruction at buffer head.
REQ-010 if_pc  output  10  index of if_insn.
REQ-011 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-012 redirect_pc  input  10  redirect target index.
REQ-013 halt_req  input  1  stop fetching; level-sensitive.
REQ-014 halted  output  1  FSM in HALT and buffer empty.

Function
REQ-015 The FSM SHALL have states FETCH, STALL and HALT.
- FETCH -> STALL when the buffer is full and no pop occurs; STALL -> FETCH when a pop occurs.
- Any state -> HALT when halt_req=1 and redirect_valid=0.
- HALT -> FETCH when halt_req=0.
REQ-016 The block SHALL push {insn_out, pc_out} into the buffer at a clk edge only in FETCH, when the buffer is not full or a pop occurs in the same cycle.
- Each push SHALL advance pc by +1, mod 1024; 1023 wraps to 0.
REQ-017 A pop SHALL occur when if_valid=1 and if_ready=1.
- if_insn and if_pc SHALL be stable while if_valid=1 and if_ready=0.
REQ-018 Fetch latency SHALL be one cycle: the instruction at pc_out in cycle N SHALL appear at the buffer head no earlier than cycle N+1.
REQ-019 Redirect SHALL have priority over push, pop, stall and halt_req.
- The buffer SHALL be flushed (count=0) and pc SHALL load redirect_pc.
- The state SHALL go to FETCH.
- No push and no pop SHALL occur in that cycle; the entry presented that cycle is discarded.
REQ-020 In HALT, pc SHALL hold and pushes SHALL cease; existing entries SHALL continue to drain through the handshake.
REQ-021 Buffer count SHALL never exceed DEPTH or underflow; push and pop in the same cycle SHALL leave count unchanged.

Reset
REQ-022 While rst=1 at a clk edge, the block SHALL set:
- pc=RESET_PC, state=FETCH, count=0;
- if_valid=0, halted=0, if_insn=0, if_pc=0.
REQ-023 Reset SHALL override redirect and halt_req, and SHALL discard buffered entries mid-operation.

Configuration
REQ-024 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs fetch_cnt[31:0] and stall_cnt[31:0], both cleared on reset.
- fetch_cnt SHALL increment per push; stall_cnt SHALL increment per cycle in STALL.
- Both counters SHALL wrap at 2^32.
REQ-025 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 A shared package SHALL hold:
- the FSM state encoding;
- the constants PC_W=10, INSN_W=32, IMEM_WORDS=1024.
REQ-027 The buffer SHALL be a sub-module fetch_fifo (synchronous FIFO, DEPTH entries of PC_W+INSN_W bits) with push, pop, flush, full, empty and count.

Verification
REQ-028 Reset release with if_ready=1, memory filled with index values -> if_valid rises in cycle 1; if_pc sequence is 0,1,2,3 with one entry per cycle.
REQ-029 if_ready=0 for 5 cycles from reset:
- buffer fills to 2 entries and state goes to STALL;
- pc_out holds at 2;
- if_pc=0 stays stable;
- after if_ready=1, if_pc sequence is 0,1,2 with no loss or duplication.
REQ-030 redirect_valid pulse with redirect_pc=10'd512 while 2 entries are buffered and if_ready=1 -> no pop that cycle; next cycle if_valid=0 and pc_out=512; following cycle if_pc=512.
REQ-031 RESET_PC=1022, if_ready=1 -> if_pc sequence is 1022,1023,0,1.
REQ-032 halt_req=1 with 2 entries buffered:
- both entries drain, then halted=1 and pc_out holds;
- halt_req=0 -> fetch resumes at the held pc.
REQ-033 rst asserted during STALL with a full buffer -> next cycle count=0, if_valid=0, pc_out=RESET_PC; with FETCH_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared definitions for the instruction fetch controller.
//   - widths of the instruction index and instruction word
//   - FSM state encoding used by fetch_ctrl
//   - the packed fetch-buffer entry layout and a small pc helper
package fetch_ctrl_pkg;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned INSN_W     = 32;
    localparam int unsigned IMEM_WORDS = 1024;
    localparam int unsigned ENTRY_W    = PC_W + INSN_W;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StStall = 2'd1,
        StHalt  = 2'd2
    } fetch_state_e;

    // One buffered instruction: the word and the index it was read from.
    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    // Sequential fetch: wraps naturally from IMEM_WORDS-1 back to 0.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO used as the fetch buffer.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   push_i     - write wdata_i; accepted when not full, or when full and popping
//   pop_i      - drop the head entry; ignored when empty
//   flush_i    - discard all entries; overrides push and pop
//   wdata_i    - entry to write
//   rdata_o    - head entry (zero when empty)
//   full_o, empty_o, count_o - occupancy
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 42,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Gated so an empty buffer presents zeros rather than stale storage.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: every read of it is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with a small fetch buffer.
// Drives pc_out to a combinational instruction memory, captures
// {insn_out, pc_out} into the buffer and hands the head to decode through a
// valid/ready handshake. Supports redirects (flush + new pc) and halting.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   pc_out, insn_out          - instruction memory address / read data
//   if_valid, if_ready        - decode handshake on the buffer head
//   if_insn, if_pc            - head instruction and its index
//   redirect_valid/pc         - single-cycle redirect request and target
//   halt_req, halted          - level halt request / halted-and-drained status
// Optional feature: define FETCH_PERF_CNT_EN to add fetch_cnt (pushes) and
// stall_cnt (cycles spent in STALL) outputs.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 10'd0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   pc_out,
    input  logic [INSN_W-1:0] insn_out,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INSN_W-1:0] if_insn,
    output logic [PC_W-1:0]   if_pc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt_req,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     wr_entry;
    fetch_entry_t     rd_entry;

    // Redirect freezes the handshake for one cycle: the head shown that
    // cycle is thrown away by the flush rather than consumed.
    assign fifo_pop  = if_valid && if_ready && !redirect_valid;
    assign fifo_push = (state_q == StFetch) && (!fifo_full || fifo_pop) && !redirect_valid;

    assign wr_entry.insn = insn_out;
    assign wr_entry.pc   = pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign pc_out   = pc_q;
    assign if_valid = (fifo_count != '0);
    assign if_insn  = rd_entry.insn;
    assign if_pc    = rd_entry.pc;
    assign halted   = (state_q == StHalt) && fifo_empty;

    // Next state: redirect beats halt, halt beats the fetch/stall flow.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = StFetch;
        end else if (halt_req) begin
            state_d = StHalt;
        end else begin
            unique case (state_q)
                StFetch: if (fifo_full && !fifo_pop) state_d = StStall;
                StStall: if (fifo_pop) state_d = StFetch;
                StHalt:  state_d = StFetch;
                default: state_d = StFetch;
            endcase
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (fifo_push) begin
            pc_d = pc_next(pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Counters are statistics only: redirects do not clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fifo_push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (state_q == StStall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
// A queue-based model of the fetch buffer is checked against the main DUT on
// every cycle; directed scenarios add hand-computed literal expectations.
// A second instance with RESET_PC=1022 covers the index wrap after reset.
module tb_fetch_ctrl;

    localparam int DEPTH = 2;
    localparam int M_FETCH = 0;
    localparam int M_STALL = 1;
    localparam int M_HALT  = 2;

    logic        clk;
    logic        rst;
    logic        if_ready;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        halt_req;

    logic [9:0]  pc_out0, if_pc0;
    logic [31:0] insn0, if_insn0;
    logic        if_valid0, halted0;

    logic [9:0]  pc_out1, if_pc1;
    logic [31:0] insn1, if_insn1;
    logic        if_valid1, halted1;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt0, stall_cnt0, fetch_cnt1, stall_cnt1;
`endif

    int errors = 0;
    int checks = 0;

    // Memory word: tag in the upper half, index in the low bits.
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    assign insn0 = mem_word(pc_out0);
    assign insn1 = mem_word(pc_out1);

    fetch_ctrl #(
        .RESET_PC (10'd0),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_out         (pc_out0),
        .insn_out       (insn0),
        .if_valid       (if_valid0),
        .if_ready       (if_ready),
        .if_insn        (if_insn0),
        .if_pc          (if_pc0),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted0)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt0),
        .stall_cnt      (stall_cnt0)
`endif
    );

    fetch_ctrl #(
        .RESET_PC (10'd1022),
        .DEPTH    (DEPTH)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .pc_out         (pc_out1),
        .insn_out       (insn1),
        .if_valid       (if_valid1),
        .if_ready       (1'b1),
        .if_insn        (if_insn1),
        .if_pc          (if_pc1),
        .redirect_valid (1'b0),
        .redirect_pc    (10'd0),
        .halt_req       (1'b0),
        .halted         (halted1)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt1),
        .stall_cnt      (stall_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [9:0] mq[$];
    logic [9:0] mpc;
    int         mmode;
    bit         model_ok = 1'b0;

    always @(posedge clk) begin : model
        bit was_full, do_pop, do_push;
        if (rst) begin
            mq.delete();
            mpc      = 10'd0;
            mmode    = M_FETCH;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (redirect_valid) begin
                mq.delete();
                mpc   = redirect_pc;
                mmode = M_FETCH;
            end else begin
                was_full = (mq.size() == DEPTH);
                do_pop   = (mq.size() != 0) && if_ready;
                do_push  = (mmode == M_FETCH) && (!was_full || do_pop);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back(mpc);
                    mpc = mpc + 10'd1;
                end
                if (halt_req) mmode = M_HALT;
                else if (mmode == M_HALT) mmode = M_FETCH;
                else if (mmode == M_FETCH && was_full && !do_pop) mmode = M_STALL;
                else if (mmode == M_STALL && do_pop) mmode = M_FETCH;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit         ok;
        bit         exp_valid;
        bit         exp_halted;
        logic [9:0] head;
        if (model_ok) begin
            exp_valid  = (mq.size() != 0);
            exp_halted = (mmode == M_HALT) && !exp_valid;
            head       = exp_valid ? mq[0] : 10'd0;
            ok = (if_valid0 === exp_valid) && (pc_out0 === mpc) && (halted0 === exp_halted);
            if (exp_valid) begin
                ok = ok && (if_pc0 === head) && (if_insn0 === mem_word(head));
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL model t=%0t: valid=%b/%b pc_out=%0d/%0d halted=%b/%b if_pc=%0d/%0d if_insn=%h/%h",
                         $time, if_valid0, exp_valid, pc_out0, mpc, halted0, exp_halted,
                         if_pc0, head, if_insn0, mem_word(head));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    // Start of a new cycle: just after the rising edge, where inputs change.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample point.
    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle with rst=0).
    task automatic do_reset();
        rst            = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 10'd0;
        halt_req       = 1'b0;
        cyc();
        cyc();
        mid();
        chk("rst_if_valid", 32'(if_valid0), 32'd0);
        chk("rst_halted", 32'(halted0), 32'd0);
        chk("rst_if_insn", if_insn0, 32'd0);
        chk("rst_if_pc", 32'(if_pc0), 32'd0);
        chk("rst_pc_out", 32'(pc_out0), 32'd0);
        cyc();
        rst = 1'b0;
    endtask

    logic [39:0] rdy_pat;
    logic [9:0]  wrap_exp [4];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 10'd0;
        halt_req       = 1'b0;
        wrap_exp[0] = 10'd1022;
        wrap_exp[1] = 10'd1023;
        wrap_exp[2] = 10'd0;
        wrap_exp[3] = 10'd1;

        // Streaming from reset, plus the RESET_PC=1022 wrap instance.
        do_reset();
        if_ready = 1'b1;
        mid();
        chk("a_c0_if_valid", 32'(if_valid0), 32'd0);
        chk("a_c0_pc_out", 32'(pc_out0), 32'd0);
        chk("a_c0_wrap_pc_out", 32'(pc_out1), 32'd1022);
        for (int k = 0; k < 4; k++) begin
            cyc();
            mid();
            chk("a_if_valid", 32'(if_valid0), 32'd1);
            chk("a_if_pc", 32'(if_pc0), 32'(k));
            chk("a_if_insn", if_insn0, 32'hC0DE_0000 + 32'(k));
            chk("a_wrap_if_pc", 32'(if_pc1), 32'(wrap_exp[k]));
        end

        // Decode not ready for 5 cycles: fill, stall, then drain in order.
        do_reset();
        cyc(); cyc(); cyc(); cyc();
        mid();
        chk("b_pc_hold", 32'(pc_out0), 32'd2);
        chk("b_if_pc_stable", 32'(if_pc0), 32'd0);
        chk("b_if_valid", 32'(if_valid0), 32'd1);
        cyc();
        if_ready = 1'b1;
        mid();
        chk("b_drain0", 32'(if_pc0), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("b_stall_cnt", stall_cnt0, 32'd2);
        chk("b_fetch_cnt", fetch_cnt0, 32'd2);
`endif
        cyc(); mid();
        chk("b_drain1", 32'(if_pc0), 32'd1);
        cyc(); mid();
        chk("b_drain2", 32'(if_pc0), 32'd2);

        // Redirect with two entries buffered and decode ready.
        do_reset();
        cyc();
        cyc();
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 10'd512;
        mid();
        chk("c_pre_if_pc", 32'(if_pc0), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        mid();
        chk("c_flush_valid", 32'(if_valid0), 32'd0);
        chk("c_flush_pc_out", 32'(pc_out0), 32'd512);
        cyc(); mid();
        chk("c_target", 32'(if_pc0), 32'd512);
        cyc(); mid();
        chk("c_target_next", 32'(if_pc0), 32'd513);

        // Halt with two entries buffered: drain, hold, resume.
        do_reset();
        cyc();
        cyc();
        halt_req = 1'b1;
        mid();
        chk("d_pc_out", 32'(pc_out0), 32'd2);
        cyc();
        if_ready = 1'b1;
        mid();
        chk("d_not_halted", 32'(halted0), 32'd0);
        chk("d_drain0", 32'(if_pc0), 32'd0);
        cyc(); mid();
        chk("d_drain1", 32'(if_pc0), 32'd1);
        cyc(); mid();
        chk("d_halted", 32'(halted0), 32'd1);
        chk("d_hold_pc", 32'(pc_out0), 32'd2);
        cyc(); mid();
        chk("d_hold_pc2", 32'(pc_out0), 32'd2);
        cyc();
        halt_req = 1'b0;
        mid();
        chk("d_still_halted", 32'(halted0), 32'd1);
        cyc(); mid();
        chk("d_resume_halted", 32'(halted0), 32'd0);
        chk("d_resume_pc", 32'(pc_out0), 32'd2);
        cyc(); mid();
        chk("d_resume_if_pc", 32'(if_pc0), 32'd2);

        // Reset in STALL with a full buffer, overriding redirect and halt.
        do_reset();
        cyc(); cyc(); cyc();
        mid();
        chk("e_stall_pc", 32'(pc_out0), 32'd2);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 10'd700;
        halt_req       = 1'b1;
        cyc();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        if_ready       = 1'b1;
        mid();
        chk("e_if_valid", 32'(if_valid0), 32'd0);
        chk("e_pc_out", 32'(pc_out0), 32'd0);
        chk("e_halted", 32'(halted0), 32'd0);
        chk("e_if_pc", 32'(if_pc0), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("e_fetch_cnt", fetch_cnt0, 32'd0);
        chk("e_stall_cnt", stall_cnt0, 32'd0);
`endif
        cyc(); mid();
        chk("e_restart", 32'(if_pc0), 32'd0);

        // Mixed traffic checked by the model: ready pattern, redirect near
        // the top of memory, a halt window, and redirect during halt.
        rdy_pat = 40'b1011_0011_1000_0111_1101_0010_1111_0001_1100_1011;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if_ready       = rdy_pat[i];
            redirect_valid = (i == 5) || (i == 22);
            redirect_pc    = (i == 5) ? 10'd1020 : 10'd300;
            halt_req       = ((i >= 12) && (i < 18)) || (i == 22) || (i == 23);
        end
        cyc();
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        if_ready       = 1'b1;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
